frame_buffer_1bpp: RTL and testbench

- 1-bit-per-pixel frame store sitting directly upstream of the VGA output stage.
- The rasteriser writes pixels by (x,y) over a valid/ready handshake.
- The VGA stage drives start_rd during its active display window, and this block returns pixel_color in raster order in the same cycle.
- A built-in clear engine zeroes the whole store on reset and whenever clr_screen is pulsed.

---
 rtl/frame_buffer_1bpp_pkg.sv | 11 +
 rtl/frame_buffer_1bpp_if.sv | 16 +
 rtl/frame_buffer_1bpp_ram.sv | 25 ++
 rtl/frame_buffer_1bpp.sv | 118 +++++++++++
 tb/tb_frame_buffer_1bpp.sv | 200 ++++++++++++++++++++
 5 files changed

// File: rtl/frame_buffer_1bpp_pkg.sv
// Shared constants and types for the 1bpp frame buffer.
package fb_pkg;
  localparam int H_PIX_DEF = 20;
  localparam int V_PIX_DEF = 20;
  localparam int XW_DEF    = 5;
  localparam int YW_DEF    = 5;
  localparam int AW_DEF    = 9;
  localparam int FB_SIZE   = H_PIX_DEF * V_PIX_DEF;

  typedef enum logic {IDLE, CLEAR} state_t;
endpackage

// File: rtl/frame_buffer_1bpp_if.sv
// Rasteriser write channel: (x,y,pixel) over valid/ready.
interface frame_buffer_1bpp_if
  import fb_pkg::*;
#(
  parameter int XW = XW_DEF,
  parameter int YW = YW_DEF
);
  logic          valid;
  logic          ready;
  logic [XW-1:0] x;
  logic [YW-1:0] y;
  logic          pixel;

  modport master (output valid, x, y, pixel, input ready);
  modport slave  (input valid, x, y, pixel, output ready);
endinterface

// File: rtl/frame_buffer_1bpp_ram.sv
// Simple dual-port 1-bit RAM: one sync write port, one sync read port.
module fb_ram #(
  parameter int AW    = 9,
  parameter int DEPTH = 400
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          i_we,
  input  logic [AW-1:0] i_waddr,
  input  logic          i_wdata,
  input  logic [AW-1:0] i_raddr,
  output logic          o_rdata
);
  logic r_mem [DEPTH];

  always_ff @(posedge clk) begin
    if (i_we) r_mem[i_waddr] <= i_wdata;
  end

  // Read register is reset so the display output is defined; contents are not.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) o_rdata <= 1'b0;
    else        o_rdata <= r_mem[i_raddr];
  end
endmodule

// File: rtl/frame_buffer_1bpp.sv
// 1bpp frame store: handshake writes, clear engine, zero-latency raster readout.
module frame_buffer_1bpp
  import fb_pkg::*;
#(
  parameter int H_PIX = H_PIX_DEF,
  parameter int V_PIX = V_PIX_DEF,
  parameter int XW    = XW_DEF,
  parameter int YW    = YW_DEF,
  parameter int AW    = AW_DEF
) (
  input  logic                clk,
  input  logic                reset,
  frame_buffer_1bpp_if.slave  wr,
  input  logic                clr_screen,
  output logic                clr_busy,
  output logic                wr_oob,
  input  logic                start_rd,
  input  logic                vsync,
  output logic                pixel_color
);
  localparam int          NPIX = H_PIX * V_PIX;
  localparam logic [AW-1:0] LAST = AW'(NPIX - 1);

  state_t        r_state;
  logic [AW-1:0] r_clr_addr;
  logic [AW-1:0] r_rd_ptr;
  logic          r_busy;
  logic          r_oob;
  logic          r_vsync_q;

  logic          w_acc;
  logic          w_inrange;
  logic          w_vs_rise;
  logic          w_we;
  logic          w_wdata;
  logic [AW-1:0] w_lin;
  logic [AW-1:0] w_waddr;
  logic [AW-1:0] w_next_ptr;

  assign wr.ready  = (r_state == IDLE) && !clr_screen;
  assign w_acc     = wr.valid && wr.ready;
  assign w_inrange = (32'(wr.x) < 32'(H_PIX)) && (32'(wr.y) < 32'(V_PIX));
  assign w_lin     = AW'(wr.x) + AW'(H_PIX) * AW'(wr.y);
  assign w_vs_rise = vsync && !r_vsync_q;
  assign clr_busy  = r_busy;
  assign wr_oob    = r_oob;

  // The clear engine owns the write port; wr.ready is low then, so no contention.
  always_comb begin
    w_we    = 1'b0;
    w_waddr = w_lin;
    w_wdata = wr.pixel;
    if (r_state == CLEAR) begin
      w_we    = 1'b1;
      w_waddr = r_clr_addr;
      w_wdata = 1'b0;
    end else if (w_acc && w_inrange) begin
      w_we = 1'b1;
    end
  end

  always_comb begin
    w_next_ptr = r_rd_ptr;
    if (w_vs_rise)     w_next_ptr = '0;
    else if (start_rd) w_next_ptr = (r_rd_ptr == LAST) ? '0 : r_rd_ptr + 1'b1;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state    <= CLEAR;
      r_clr_addr <= '0;
      r_busy     <= 1'b1;
      r_oob      <= 1'b0;
    end else begin
      case (r_state)
        CLEAR: begin
          if (r_clr_addr == LAST) begin
            r_state    <= IDLE;
            r_busy     <= 1'b0;
            r_clr_addr <= '0;
          end else begin
            r_clr_addr <= r_clr_addr + 1'b1;
          end
        end
        default: begin
          if (clr_screen) begin
            r_state <= CLEAR;
            r_busy  <= 1'b1;
            r_oob   <= 1'b0;
          end else if (w_acc && !w_inrange) begin
            r_oob <= 1'b1;
          end
        end
      endcase
    end
  end

  // Reading next_ptr keeps pixel_color equal to mem[rd_ptr] every cycle.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_rd_ptr  <= '0;
      r_vsync_q <= 1'b0;
    end else begin
      r_rd_ptr  <= w_next_ptr;
      r_vsync_q <= vsync;
    end
  end

  fb_ram #(.AW(AW), .DEPTH(NPIX)) u_ram (
    .clk     (clk),
    .rst_n   (reset),
    .i_we    (w_we),
    .i_waddr (w_waddr),
    .i_wdata (w_wdata),
    .i_raddr (w_next_ptr),
    .o_rdata (pixel_color)
  );
endmodule

// File: tb/tb_frame_buffer_1bpp.sv
// Scoreboard bench: the driver queues expectations per cycle, a negedge monitor checks them.
module tb_frame_buffer_1bpp;
  localparam int S_PIX = 0, S_BUSY = 1, S_RDY = 2, S_OOB = 3;
  localparam int NP = 400;

  typedef struct {
    int    cyc;
    int    sig;
    logic  exp;
    string name;
  } chk_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic clr_screen = 1'b0, start_rd = 1'b0, vsync = 1'b0;
  logic clr_busy, wr_oob, pixel_color;

  frame_buffer_1bpp_if #(.XW(5), .YW(5)) wif ();

  frame_buffer_1bpp dut (
    .clk         (clk),
    .reset       (rst_n),
    .wr          (wif),
    .clr_screen  (clr_screen),
    .clr_busy    (clr_busy),
    .wr_oob      (wr_oob),
    .start_rd    (start_rd),
    .vsync       (vsync),
    .pixel_color (pixel_color)
  );

  always #5 clk = ~clk;

  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;
  chk_t q[$];
  chk_t it;
  logic act;
  bit   model [NP];
  int   p = 0;
  logic oob_m = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    while (q.size() > 0 && q[0].cyc <= cyc) begin
      it = q.pop_front();
      case (it.sig)
        S_PIX:   act = pixel_color;
        S_BUSY:  act = clr_busy;
        S_RDY:   act = wif.ready;
        default: act = wr_oob;
      endcase
      checks++;
      if (it.cyc != cyc || act !== it.exp) begin
        errors++;
        $display("FAIL %s cyc=%0d (due %0d) got=%b want=%b", it.name, cyc, it.cyc, act, it.exp);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic expect_sig(input int sig, input logic v, input string nm);
    chk_t c;
    c.cyc = cyc; c.sig = sig; c.exp = v; c.name = nm;
    q.push_back(c);
  endtask

  task automatic wr(input int x, input int y, input logic pix);
    wif.valid = 1'b1; wif.x = 5'(x); wif.y = 5'(y); wif.pixel = pix;
    expect_sig(S_RDY, 1'b1, "wr_ready");
    tick();
    wif.valid = 1'b0;
    if (x < 20 && y < 20) model[x + 20*y] = pix;
    else oob_m = 1'b1;
    expect_sig(S_OOB, oob_m, "wr_oob");
  endtask

  task automatic rd(input int n);
    for (int i = 0; i < n; i++) begin
      start_rd = 1'b1;
      expect_sig(S_PIX, model[p], "pixel");
      p = (p == NP-1) ? 0 : p + 1;
      tick();
    end
    start_rd = 1'b0;
  endtask

  // Caller arranges that the FSM is already in CLEAR on entry.
  task automatic clear_run(input int reissue_at);
    for (int i = 0; i < NP; i++) begin
      expect_sig(S_BUSY, 1'b1, "clr_busy_on");
      expect_sig(S_RDY, 1'b0, "wr_ready_clr");
      if (i == 0) expect_sig(S_OOB, 1'b0, "oob_cleared");
      if (i == reissue_at) clr_screen = 1'b1;
      tick();
      clr_screen = 1'b0;
    end
    for (int i = 0; i < NP; i++) model[i] = 1'b0;
    oob_m = 1'b0;
    expect_sig(S_BUSY, 1'b0, "clr_busy_off");
    expect_sig(S_RDY, 1'b1, "wr_ready_idle");
  endtask

  initial begin
    wif.valid = 1'b0; wif.x = '0; wif.y = '0; wif.pixel = 1'b0;
    tick(); tick();
    expect_sig(S_BUSY, 1'b1, "rst_busy");
    expect_sig(S_RDY, 1'b0, "rst_ready");
    expect_sig(S_OOB, 1'b0, "rst_oob");
    expect_sig(S_PIX, 1'b0, "rst_pix");
    tick();
    rst_n = 1'b1;
    clear_run(-1);
    tick();
    rd(NP);

    // single pixel at (3,2) -> addr 43; 401 strobes also cover the wrap
    wr(3, 2, 1'b1);
    rd(NP + 1);

    // out-of-range writes; (20,0) aliases addr 20 if the guard is missing
    wr(20, 0, 1'b1);
    wr(0, 25, 1'b1);
    rd(NP);

    // clear beats a simultaneous write; a mid-clear request is ignored
    clr_screen = 1'b1;
    wif.valid = 1'b1; wif.x = 5'd5; wif.y = 5'd5; wif.pixel = 1'b1;
    expect_sig(S_RDY, 1'b0, "clr_vs_wr_ready");
    tick();
    clr_screen = 1'b0; wif.valid = 1'b0;
    clear_run(100);
    rd(NP);

    // vsync realignment, then held vsync must not re-zero the pointer
    wr(0, 0, 1'b1);
    rd(150);
    vsync = 1'b1; start_rd = 1'b1;
    expect_sig(S_PIX, model[p], "pix_at_vsync");
    tick();
    p = 0;
    expect_sig(S_PIX, 1'b1, "vsync_addr0");
    tick();
    expect_sig(S_PIX, 1'b0, "vsync_held_addr1");
    tick();
    p = 2;
    start_rd = 1'b0; vsync = 1'b0;

    // write to the address being read: old value for one cycle, then new
    wif.valid = 1'b1; wif.x = 5'd2; wif.y = 5'd0; wif.pixel = 1'b1;
    expect_sig(S_RDY, 1'b1, "coll_ready");
    expect_sig(S_PIX, 1'b0, "coll_before");
    tick();
    wif.valid = 1'b0;
    expect_sig(S_PIX, 1'b0, "coll_old");
    tick();
    expect_sig(S_PIX, 1'b1, "coll_new");
    model[2] = 1'b1;
    tick();

    // park pointer on addr 300 (=1), then reset 200 cycles into a clear
    wr(0, 15, 1'b1);
    rd(300 - p);
    expect_sig(S_PIX, 1'b1, "park_300");
    clr_screen = 1'b1;
    tick();
    clr_screen = 1'b0;
    for (int i = 0; i < 200; i++) begin
      expect_sig(S_BUSY, 1'b1, "clr_busy_pre_rst");
      if (i == 199) expect_sig(S_PIX, 1'b1, "mid_clear_pix");
      tick();
    end
    rst_n = 1'b0;
    expect_sig(S_BUSY, 1'b1, "async_rst_busy");
    expect_sig(S_RDY, 1'b0, "async_rst_ready");
    expect_sig(S_OOB, 1'b0, "async_rst_oob");
    expect_sig(S_PIX, 1'b0, "async_rst_pix");
    tick(); tick();
    rst_n = 1'b1;
    p = 0;
    clear_run(-1);
    tick();
    rd(5);

    tick(); tick(); tick();
    checks++;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain left=%0d want=0", q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
